// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// false-start rejection, configurable width/parity/stop bits, parity and framing flags.
module uart_rx_param #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned OVS       = 16,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 DataIn,
    output logic [DATA_BITS-1:0] Data,
    output logic                 DataEn,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Busy
);

    localparam int unsigned OsW    = $clog2(OVS);
    localparam int unsigned BitW   = $clog2(DATA_BITS + 4);
    localparam int unsigned HasPar = (PARITY != 0) ? 1 : 0;

    localparam logic [OsW-1:0]  OsSamp0  = OsW'(OVS / 2 - 1);
    localparam logic [OsW-1:0]  OsSamp1  = OsW'(OVS / 2);
    localparam logic [OsW-1:0]  OsDecide = OsW'(OVS / 2 + 1);
    localparam logic [OsW-1:0]  OsLast   = OsW'(OVS - 1);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS);
    localparam logic [BitW-1:0] LastStop = BitW'(DATA_BITS + HasPar + STOP_BITS);
    localparam logic            OddPar   = (PARITY == 2);

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic                 rx_meta_q, rx_s_q;
    logic [OsW-1:0]       os_cnt_q, os_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_en_q, data_en_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic rx_s;
    logic maj;
    logic decide;
    logic bit_end;

    assign rx_s    = rx_s_q;
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign decide  = (os_cnt_q == OsDecide);
    assign bit_end = (os_cnt_q == OsLast);

    always_comb begin
        state_d      = state_q;
        os_cnt_d     = bit_end ? '0 : os_cnt_q + OsW'(1);
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        data_d       = data_q;
        data_en_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (os_cnt_q == OsSamp0) begin
            samp_d[0] = rx_s;
        end
        if (os_cnt_q == OsSamp1) begin
            samp_d[1] = rx_s;
        end

        unique case (state_q)
            StArm: begin
                os_cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                os_cnt_d = '0;
                if (!rx_s) begin
                    // The cycle that sees the falling edge is offset 0 of the start bit.
                    state_d   = StStart;
                    os_cnt_d  = OsW'(1);
                    bit_cnt_d = '0;
                    par_acc_d = 1'b0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d  = StIdle;
                    os_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end
            end
            StData: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ maj;
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == LastData) begin
                        state_d = (HasPar != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (decide && ((par_acc_q ^ maj) != OddPar)) begin
                    par_err_d = 1'b1;
                end
                if (bit_end) begin
                    state_d   = StStop;
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end
            end
            StStop: begin
                if (decide) begin
                    if (!maj) begin
                        frm_err_d = 1'b1;
                    end
                    if (bit_cnt_q == LastStop) begin
                        // Leave mid stop bit so a start edge at the nominal bit end is caught.
                        data_d       = shift_q;
                        data_en_d    = 1'b1;
                        parity_err_d = par_err_q;
                        frame_err_d  = frm_err_q | ~maj;
                        state_d      = maj ? StIdle : StArm;
                        os_cnt_d     = '0;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end
            end
            default: begin
                state_d  = StArm;
                os_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= StArm;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            data_q       <= '0;
            data_en_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= DataIn;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            data_q       <= data_d;
            data_en_q    <= data_en_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign Data      = data_q;
    assign DataEn    = data_en_q;
    assign ParityErr = parity_err_q;
    assign FrameErr  = frame_err_q;
    assign Busy      = (state_q != StArm) && (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and a 7-bit even-parity 2-stop instance, driven by
// frame-level stimulus and checked against expected words, flags and arrival cycles.
module tb_uart_rx_param;

    localparam int OVS = 16;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic line0, line1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic en0, pe0, fe0, busy0;
    logic en1, pe1, fe1, busy1;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int stray0 = 0;
    int stray1 = 0;
    logic [7:0] prev0 = '0;
    logic [6:0] prev1 = '0;
    ev_t obs0[$];
    ev_t obs1[$];

    uart_rx_param #(.DATA_BITS(8), .OVS(OVS), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .DataIn   (line0),
        .Data     (data0),
        .DataEn   (en0),
        .ParityErr(pe0),
        .FrameErr (fe0),
        .Busy     (busy0)
    );

    uart_rx_param #(.DATA_BITS(7), .OVS(OVS), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .DataIn   (line1),
        .Data     (data1),
        .DataEn   (en1),
        .ParityErr(pe1),
        .FrameErr (fe1),
        .Busy     (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t make_ev(logic [8:0] d, logic p, logic f, int c);
        ev_t e;
        e.data = d;
        e.pe   = p;
        e.fe   = f;
        e.cyc  = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (en0) obs0.push_back(make_ev(9'(data0), pe0, fe0, cyc));
        if (en1) obs1.push_back(make_ev(9'(data1), pe1, fe1, cyc));
        if (reset && !en0 && (data0 != prev0)) stray0 <= stray0 + 1;
        if (reset && !en1 && (data1 != prev1)) stray1 <= stray1 + 1;
        prev0 <= data0;
        prev1 <= data1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clocks from the line falling to DataEn being visible: synchroniser, decision point of the
    // last stop bit, output register.
    function automatic int lat_of(int nbits, int haspar, int nstop);
        return 2 + ((nbits + haspar + nstop) * OVS + OVS / 2 + 1) + 1;
    endfunction

    task automatic drive(input int sel, input logic v);
        if (sel == 0) line0 = v;
        else line1 = v;
    endtask

    // Called on a negedge; one pin value per clock, bit boundaries every OVS clocks.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int pbit, input logic [1:0] stops, input int nstop,
                              input int glitch_at, input int abort_at, output int fall);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (pbit >= 0) bits.push_back(pbit[0]);
        for (int s = 0; s < nstop; s++) bits.push_back(stops[s]);
        fall = cyc;
        for (int j = 0; j < bits.size() * OVS; j++) begin
            if (j == abort_at) return;
            drive(sel, bits[j / OVS] ^ (j == glitch_at));
            @(negedge clk);
        end
    endtask

    task automatic expect_ev(input int sel, input string tag, input logic [8:0] d, input logic pe,
                             input logic fe, input int fall, input int lat);
        ev_t e;
        int n;
        n = (sel == 0) ? obs0.size() : obs1.size();
        check({tag, "_count"}, n, 1);
        if (n > 0) begin
            if (sel == 0) e = obs0.pop_front();
            else e = obs1.pop_front();
            check({tag, "_data"}, e.data, d);
            check({tag, "_perr"}, e.pe, pe);
            check({tag, "_ferr"}, e.fe, fe);
            check({tag, "_latency"}, e.cyc - fall, lat);
        end
    endtask

    initial begin
        int fall;
        int waited;
        logic [8:0] d;
        logic [7:0] last0;
        logic good;
        logic pbit;
        logic [1:0] stops;
        int k;

        reset = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data0", data0, 0);
        check("rst_en0", en0, 0);
        check("rst_perr0", pe0, 0);
        check("rst_ferr0", fe0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_data1", data1, 0);
        check("rst_busy1", busy1, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(0, 9'h0A5, 8, -1, 2'b01, 1, -1, -1, fall);
        expect_ev(0, "a5", 9'h0A5, 1'b0, 1'b0, fall, lat_of(8, 0, 1));
        last0 = 8'hA5;

        for (int i = 0; i < 8; i++) begin
            d = 9'($urandom_range(0, 255));
            send_frame(0, d, 8, -1, 2'b01, 1, -1, -1, fall);
            expect_ev(0, "rand8n1", d, 1'b0, 1'b0, fall, lat_of(8, 0, 1));
            last0 = d[7:0];
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        send_frame(1, 9'h041, 7, 0, 2'b11, 2, -1, -1, fall);
        expect_ev(1, "p41_ok", 9'h041, 1'b0, 1'b0, fall, lat_of(7, 1, 2));
        send_frame(1, 9'h041, 7, 1, 2'b11, 2, -1, -1, fall);
        expect_ev(1, "p41_bad", 9'h041, 1'b1, 1'b0, fall, lat_of(7, 1, 2));

        for (int i = 0; i < 10; i++) begin
            d = 9'($urandom_range(0, 127));
            good = ($urandom_range(0, 2) != 0);
            pbit = good ? ^d[6:0] : ~^d[6:0];
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send_frame(1, d, 7, int'(pbit), stops, 2, -1, -1, fall);
            expect_ev(1, "rand7e2", d, ~good, stops != 2'b11, fall, lat_of(7, 1, 2));
            drive(1, 1'b1);
            repeat ($urandom_range(2, 8)) @(negedge clk);
        end

        // Short low pulse on an idle line must be rejected as a false start.
        drive(0, 1'b0);
        repeat (4) @(negedge clk);
        check("fs_busy_set", busy0, 1);
        @(negedge clk);
        drive(0, 1'b1);
        waited = 0;
        while (busy0 && waited < OVS) begin
            @(negedge clk);
            waited++;
        end
        check("fs_busy_clear", busy0, 0);
        repeat (OVS) @(negedge clk);
        check("fs_no_event", obs0.size(), 0);
        check("fs_data_kept", data0, last0);

        k = $urandom_range(1, 8);
        send_frame(0, 9'h0FF, 8, -1, 2'b01, 1, k * OVS + OVS / 2, -1, fall);
        expect_ev(0, "glitch_mid", 9'h0FF, 1'b0, 1'b0, fall, lat_of(8, 0, 1));
        k = $urandom_range(1, 8);
        send_frame(0, 9'h0FF, 8, -1, 2'b01, 1, k * OVS + $urandom_range(OVS / 2 - 1, OVS / 2 + 1),
                   -1, fall);
        expect_ev(0, "glitch_any", 9'h0FF, 1'b0, 1'b0, fall, lat_of(8, 0, 1));

        // Stop bit low, then a long break: exactly one framed word, nothing more until idle.
        d = 9'($urandom_range(0, 255));
        send_frame(0, d, 8, -1, 2'b00, 1, -1, -1, fall);
        repeat (40 * OVS) @(negedge clk);
        expect_ev(0, "break", d, 1'b0, 1'b1, fall, lat_of(8, 0, 1));
        drive(0, 1'b1);
        repeat (3 * OVS) @(negedge clk);
        check("break_quiet", obs0.size(), 0);
        check("break_busy", busy0, 0);
        send_frame(0, 9'h03C, 8, -1, 2'b01, 1, -1, -1, fall);
        expect_ev(0, "after_break", 9'h03C, 1'b0, 1'b0, fall, lat_of(8, 0, 1));

        send_frame(0, 9'h012, 8, -1, 2'b01, 1, -1, -1, fall);
        expect_ev(0, "b2b_12", 9'h012, 1'b0, 1'b0, fall, lat_of(8, 0, 1));
        send_frame(0, 9'h034, 8, -1, 2'b01, 1, -1, -1, fall);
        expect_ev(0, "b2b_34", 9'h034, 1'b0, 1'b0, fall, lat_of(8, 0, 1));

        // Reset during data bit 4 of a third frame aborts it outright.
        send_frame(0, 9'h0C3, 8, -1, 2'b01, 1, -1, 4 * OVS + 6, fall);
        #2 reset = 1'b0;
        #1;
        check("midrst_data", data0, 0);
        check("midrst_en", en0, 0);
        check("midrst_perr", pe0, 0);
        check("midrst_ferr", fe0, 0);
        check("midrst_busy", busy0, 0);
        drive(0, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * OVS) @(negedge clk);
        check("midrst_no_event", obs0.size(), 0);
        send_frame(0, 9'h056, 8, -1, 2'b01, 1, -1, -1, fall);
        expect_ev(0, "after_rst", 9'h056, 1'b0, 1'b0, fall, lat_of(8, 0, 1));

        repeat (OVS) @(negedge clk);
        check("end_quiet0", obs0.size(), 0);
        check("end_quiet1", obs1.size(), 0);
        check("data_stable0", stray0, 0);
        check("data_stable1", stray1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
